next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
//  Clocked next-PC generator; successor to the single-mode jump block.
//  Resolves sequential, J, JAL, JR, resolved-branch and RET requests into a registered
//  next PC, with valid/ready request handshake and one-cycle done pulse.
//  Adds a JAL/RET return-address stack (RAS), configurable PC/field widths and
//  word- or byte-indexed PC. Sits between control FSM and the PC register.
// PARAMETERS
//  PC_W       32  PC and register-target width
//  ADDR_W     26  J/JAL target field width (ADDR_W+2 <= PC_W)
//  WORD_ADDR  1   1: PC counts words (step 1, reg targets >>2); 0: bytes (step 4)
//  RAS_DEPTH  4   return-address stack entries (>=2, power of 2)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       unit can accept (high only in IDLE)
//  op         in   3       0 SEQ, 1 J, 2 JAL, 3 JR, 4 BR, 5 RET, 6/7 treated as SEQ
//  pc         in   PC_W    current PC
//  addr       in   ADDR_W  J/JAL target field
//  imm        in   16      BR signed offset, in instructions
//  taken      in   1       BR resolved outcome
//  reg_addr   in   PC_W    JR/RET register target (always a byte address)
//  pc_out     out  PC_W    registered next PC
//  link_out   out  PC_W    return address (pc+STEP) for JAL
//  link_we    out  1       pulse with done on JAL
//  done       out  1       one-cycle completion pulse
//  misalign   out  1       with done: JR/RET-fallback reg_addr[1:0]!=0
//  ras_miss   out  1       with done: RET on empty RAS
// BEHAVIOUR
//  Reset: pc_out, link_out=0; link_we, done, misalign, ras_miss=0; state IDLE;
//   RAS count=0, pointer=0. Reset in any state aborts request: no done, no RAS update.
//  FSM IDLE->EXEC->RESP->IDLE. IDLE: req_ready=1; on req_valid latch all inputs,
//   go EXEC. EXEC: compute target, write pc_out, update RAS. RESP: done=1 (plus
//   link_we/misalign/ras_miss as applicable) for exactly one cycle.
//   done rises 2 cycles after acceptance edge; throughput one request per 3 cycles.
//  Inputs ignored outside IDLE; pc_out holds until next EXEC.
//  STEP = WORD_ADDR ? 1 : 4. All adds modulo 2^PC_W (wrap silently).
//  SEQ: pc+STEP. BR: taken ? pc+STEP+sext(imm)*STEP : pc+STEP.
//  J/JAL: WORD_ADDR ? {pc[PC_W-1:ADDR_W],addr} : {pc[PC_W-1:ADDR_W+2],addr,2'b00}.
//  JAL also: link_out=pc+STEP, push pc+STEP on RAS.
//  JR: WORD_ADDR ? reg_addr>>2 : reg_addr; misalign=|reg_addr[1:0], target still
//   taken (truncated in word mode, unmodified in byte mode).
//  RAS push when full: overwrite oldest entry, count stays RAS_DEPTH.
//  RET: count>0 -> target=top entry, count-1, reg_addr ignored; count==0 ->
//   JR rule on reg_addr, ras_miss=1, misalign per JR rule.
//  Non-JAL ops never write link_out.
// TESTING
//  1 WORD_ADDR=1: rst, SEQ pc=0x10 -> done at acceptance+2, pc_out=0x11, req_ready
//    low two cycles.
//  2 J pc=0xF000_0040 addr=0x0000123 -> pc_out=0xF000_0123; byte mode ->
//    0xF000_048C.
//  3 BR pc=0x20 imm=-3 taken=1 -> 0x1E; taken=0 -> 0x21; pc=0xFFFF_FFFF imm=0
//    taken=1 -> wraps to 0x0000_0000.
//  4 RAS_DEPTH=4: 5 JALs at pc=0x100..0x104 -> link_we each; 5 RETs -> 0x105,
//    0x104,0x103,0x102, then ras_miss=1 with pc_out=reg_addr>>2.
//  5 JR reg_addr=0x0000_0042 -> pc_out=0x10, misalign=1; reg_addr=0x40 -> misalign=0.
//  6 rst asserted in EXEC of JAL -> no done, RAS count 0, outputs 0; next RET ->
//    ras_miss=1.

Source files
------------

// File: rtl/next_pc_unit.sv
// Clocked next-PC generator: resolves SEQ/J/JAL/JR/BR/RET into a registered next PC
// through an IDLE->EXEC->RESP handshake, with a JAL/RET return-address stack.
module next_pc_unit #(
    parameter int PC_W      = 32,
    parameter int ADDR_W    = 26,
    parameter int WORD_ADDR = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        op,
    input  logic [PC_W-1:0]   pc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       imm,
    input  logic              taken,
    input  logic [PC_W-1:0]   reg_addr,
    output logic [PC_W-1:0]   pc_out,
    output logic [PC_W-1:0]   link_out,
    output logic              link_we,
    output logic              done,
    output logic              misalign,
    output logic              ras_miss
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_SEQ = 3'd0;
    localparam logic [2:0] OP_J   = 3'd1;
    localparam logic [2:0] OP_JAL = 3'd2;
    localparam logic [2:0] OP_JR  = 3'd3;
    localparam logic [2:0] OP_BR  = 3'd4;
    localparam logic [2:0] OP_RET = 3'd5;

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    localparam logic [PC_W-1:0] STEP = (WORD_ADDR != 0) ? PC_W'(1) : PC_W'(4);
    // Low PC bits replaced by the J/JAL field; shift by PC_W yields zero, so mask becomes all ones.
    localparam int J_LOW = (WORD_ADDR != 0) ? ADDR_W : ADDR_W + 2;
    localparam logic [PC_W-1:0] J_MASK = (PC_W'(1) << J_LOW) - PC_W'(1);

    logic [1:0]        state_reg;
    logic [2:0]        op_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       imm_reg;
    logic              taken_reg;
    logic [PC_W-1:0]   reg_addr_reg;

    logic [PC_W-1:0]   pc_out_reg;
    logic [PC_W-1:0]   link_out_reg;
    logic              link_we_reg;
    logic              done_reg;
    logic              misalign_reg;
    logic              ras_miss_reg;

    logic [PTR_W-1:0]  ras_ptr_reg;
    logic [CNT_W-1:0]  ras_cnt_reg;
    logic [RAS_DEPTH-1:0][PC_W-1:0] ras_flat;

    logic [PC_W-1:0]   seq_pc;
    logic [PC_W-1:0]   addr_ext;
    logic [PC_W-1:0]   j_target;
    logic [PC_W-1:0]   imm_ext;
    logic [PC_W-1:0]   br_off;
    logic [PC_W-1:0]   jr_target;
    logic              jr_misalign;
    logic [PC_W-1:0]   ras_top;

    logic [PC_W-1:0]   target_next;
    logic              misalign_next;
    logic              ras_miss_next;
    logic              link_we_next;
    logic              ras_push_op;
    logic              ras_pop_op;
    logic              ras_we;

    assign req_ready = (state_reg == ST_IDLE);
    assign pc_out    = pc_out_reg;
    assign link_out  = link_out_reg;
    assign link_we   = link_we_reg;
    assign done      = done_reg;
    assign misalign  = misalign_reg;
    assign ras_miss  = ras_miss_reg;

    assign seq_pc      = pc_reg + STEP;
    assign addr_ext    = {{(PC_W-ADDR_W){1'b0}}, addr_reg};
    assign j_target    = (pc_reg & ~J_MASK) | ((WORD_ADDR != 0) ? addr_ext : (addr_ext << 2));
    assign imm_ext     = {{(PC_W-16){imm_reg[15]}}, imm_reg};
    assign br_off      = (WORD_ADDR != 0) ? imm_ext : (imm_ext << 2);
    // Register targets are byte addresses regardless of PC indexing.
    assign jr_target   = (WORD_ADDR != 0) ? (reg_addr_reg >> 2) : reg_addr_reg;
    assign jr_misalign = |reg_addr_reg[1:0];
    assign ras_top     = ras_flat[ras_ptr_reg - PTR_W'(1)];

    always_comb begin
        target_next   = seq_pc;
        misalign_next = 1'b0;
        ras_miss_next = 1'b0;
        link_we_next  = 1'b0;
        ras_push_op   = 1'b0;
        ras_pop_op    = 1'b0;
        case (op_reg)
            OP_J: target_next = j_target;
            OP_JAL: begin
                target_next  = j_target;
                link_we_next = 1'b1;
                ras_push_op  = 1'b1;
            end
            OP_JR: begin
                target_next   = jr_target;
                misalign_next = jr_misalign;
            end
            OP_BR: target_next = taken_reg ? (seq_pc + br_off) : seq_pc;
            OP_RET: begin
                if (ras_cnt_reg != '0) begin
                    target_next = ras_top;
                    ras_pop_op  = 1'b1;
                end else begin
                    target_next   = jr_target;
                    misalign_next = jr_misalign;
                    ras_miss_next = 1'b1;
                end
            end
            default: target_next = seq_pc;
        endcase
    end

    assign ras_we = (state_reg == ST_EXEC) && ras_push_op;

    // Circular stack: the write pointer wraps, so a push when full overwrites the oldest entry.
    genvar gi;
    generate
        for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            logic [PC_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (!rst && ras_we && (ras_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= seq_pc;
                end
            end
            assign ras_flat[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_SEQ;
            pc_reg       <= '0;
            addr_reg     <= '0;
            imm_reg      <= '0;
            taken_reg    <= 1'b0;
            reg_addr_reg <= '0;
            pc_out_reg   <= '0;
            link_out_reg <= '0;
            link_we_reg  <= 1'b0;
            done_reg     <= 1'b0;
            misalign_reg <= 1'b0;
            ras_miss_reg <= 1'b0;
            ras_ptr_reg  <= '0;
            ras_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg       <= op;
                        pc_reg       <= pc;
                        addr_reg     <= addr;
                        imm_reg      <= imm;
                        taken_reg    <= taken;
                        reg_addr_reg <= reg_addr;
                        state_reg    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc_out_reg   <= target_next;
                    if (link_we_next) begin
                        link_out_reg <= seq_pc;
                    end
                    link_we_reg  <= link_we_next;
                    misalign_reg <= misalign_next;
                    ras_miss_reg <= ras_miss_next;
                    done_reg     <= 1'b1;
                    if (ras_push_op) begin
                        ras_ptr_reg <= ras_ptr_reg + PTR_W'(1);
                        if (ras_cnt_reg != CNT_FULL) begin
                            ras_cnt_reg <= ras_cnt_reg + CNT_W'(1);
                        end
                    end else if (ras_pop_op) begin
                        ras_ptr_reg <= ras_ptr_reg - PTR_W'(1);
                        ras_cnt_reg <= ras_cnt_reg - CNT_W'(1);
                    end
                    state_reg <= ST_RESP;
                end
                ST_RESP: begin
                    link_we_reg  <= 1'b0;
                    misalign_reg <= 1'b0;
                    ras_miss_reg <= 1'b0;
                    done_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: word-mode and byte-mode instances driven with the same requests,
// each compared against a behavioural next-PC/return-stack model.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  op;
    logic [31:0] pc;
    logic [25:0] addr;
    logic [15:0] imm;
    logic        taken;
    logic [31:0] reg_addr;

    // index 0: word-indexed instance, index 1: byte-indexed instance
    logic [1:0]        req_ready_v;
    logic [1:0]        link_we_v;
    logic [1:0]        done_v;
    logic [1:0]        misalign_v;
    logic [1:0]        ras_miss_v;
    logic [1:0][31:0]  pc_out_v;
    logic [1:0][31:0]  link_out_v;

    int tests = 0;
    int fails = 0;

    logic [31:0] ras_w[$];
    logic [31:0] ras_b[$];
    logic [31:0] exp_pc[2];
    logic [31:0] exp_link[2];
    logic        exp_lwe[2];
    logic        exp_mis[2];
    logic        exp_miss[2];

    always #5 clk = ~clk;

    next_pc_unit #(.PC_W(32), .ADDR_W(26), .WORD_ADDR(1), .RAS_DEPTH(4)) dut_word (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_v[0]),
        .op(op), .pc(pc), .addr(addr), .imm(imm), .taken(taken), .reg_addr(reg_addr),
        .pc_out(pc_out_v[0]), .link_out(link_out_v[0]), .link_we(link_we_v[0]),
        .done(done_v[0]), .misalign(misalign_v[0]), .ras_miss(ras_miss_v[0])
    );

    next_pc_unit #(.PC_W(32), .ADDR_W(26), .WORD_ADDR(0), .RAS_DEPTH(4)) dut_byte (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_v[1]),
        .op(op), .pc(pc), .addr(addr), .imm(imm), .taken(taken), .reg_addr(reg_addr),
        .pc_out(pc_out_v[1]), .link_out(link_out_v[1]), .link_we(link_we_v[1]),
        .done(done_v[1]), .misalign(misalign_v[1]), .ras_miss(ras_miss_v[1])
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        ras_w.delete();
        ras_b.delete();
        for (int m = 0; m < 2; m++) begin
            exp_pc[m]   = '0;
            exp_link[m] = '0;
            exp_lwe[m]  = 1'b0;
            exp_mis[m]  = 1'b0;
            exp_miss[m] = 1'b0;
        end
    endtask

    // Next-PC rules computed with plain integer arithmetic on 64-bit values, truncated to 32 bits.
    task automatic model_req(input int m, input logic [2:0] o, input logic [31:0] p,
                             input logic [25:0] a, input logic [15:0] im, input logic tk,
                             input logic [31:0] ra);
        longint t;
        longint step;
        longint jr;
        logic [31:0] link;
        step = (m == 0) ? 64'd1 : 64'd4;
        jr   = (m == 0) ? longint'(ra) / 4 : longint'(ra);
        exp_lwe[m]  = 1'b0;
        exp_mis[m]  = 1'b0;
        exp_miss[m] = 1'b0;
        link = 32'(longint'(p) + step);
        case (o)
            3'd1, 3'd2: begin
                if (m == 0) t = (longint'(p) / 64'd67108864) * 64'd67108864 + longint'(a);
                else        t = (longint'(p) / 64'd268435456) * 64'd268435456 + longint'(a) * 4;
                if (o == 3'd2) begin
                    exp_lwe[m]  = 1'b1;
                    exp_link[m] = link;
                    if (m == 0) begin
                        ras_w.push_back(link);
                        if (ras_w.size() > 4) void'(ras_w.pop_front());
                    end else begin
                        ras_b.push_back(link);
                        if (ras_b.size() > 4) void'(ras_b.pop_front());
                    end
                end
            end
            3'd3: begin
                t = jr;
                exp_mis[m] = (ra % 4) != 0;
            end
            3'd4: t = longint'(p) + step + (tk ? longint'($signed(im)) * step : 64'd0);
            3'd5: begin
                if (m == 0 && ras_w.size() > 0)      t = longint'(ras_w.pop_back());
                else if (m == 1 && ras_b.size() > 0) t = longint'(ras_b.pop_back());
                else begin
                    t = jr;
                    exp_miss[m] = 1'b1;
                    exp_mis[m]  = (ra % 4) != 0;
                end
            end
            default: t = longint'(p) + step;
        endcase
        exp_pc[m] = t[31:0];
    endtask

    task automatic do_req(input logic [2:0] o, input logic [31:0] p, input logic [25:0] a,
                          input logic [15:0] im, input logic tk, input logic [31:0] ra);
        @(negedge clk);
        op = o; pc = p; addr = a; imm = im; taken = tk; reg_addr = ra;
        req_valid = 1'b1;
        for (int m = 0; m < 2; m++) model_req(m, o, p, a, im, tk, ra);
        tests++;
        if (req_ready_v !== 2'b11) begin
            fails++;
            $display("FAIL idle_ready: got %b expected 11", req_ready_v);
        end
        @(posedge clk); #1;
        // Garbage with valid still high must be ignored while busy.
        op = 3'($urandom); pc = $urandom; addr = 26'($urandom); imm = 16'($urandom);
        taken = 1'($urandom); reg_addr = $urandom;
        tests++;
        if (req_ready_v !== 2'b00 || done_v !== 2'b00) begin
            fails++;
            $display("FAIL exec_phase: ready=%b done=%b expected 00/00", req_ready_v, done_v);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int m = 0; m < 2; m++) begin
            tests++;
            if (done_v[m] !== 1'b1 || pc_out_v[m] !== exp_pc[m] || link_we_v[m] !== exp_lwe[m] ||
                misalign_v[m] !== exp_mis[m] || ras_miss_v[m] !== exp_miss[m] ||
                link_out_v[m] !== exp_link[m] || req_ready_v[m] !== 1'b0) begin
                fails++;
                $display("FAIL resp_inst%0d op=%0d: done=%b pc_out=%h lwe=%b mis=%b miss=%b link=%h rdy=%b expected 1 %h %b %b %b %h 0",
                         m, o, done_v[m], pc_out_v[m], link_we_v[m], misalign_v[m], ras_miss_v[m],
                         link_out_v[m], req_ready_v[m], exp_pc[m], exp_lwe[m], exp_mis[m],
                         exp_miss[m], exp_link[m]);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (done_v !== 2'b00 || req_ready_v !== 2'b11 || link_we_v !== 2'b00 ||
            misalign_v !== 2'b00 || ras_miss_v !== 2'b00 ||
            pc_out_v[0] !== exp_pc[0] || pc_out_v[1] !== exp_pc[1]) begin
            fails++;
            $display("FAIL resp_end: done=%b rdy=%b lwe=%b mis=%b miss=%b pc=%h/%h expected 00 11 00 00 00 %h/%h",
                     done_v, req_ready_v, link_we_v, misalign_v, ras_miss_v,
                     pc_out_v[0], pc_out_v[1], exp_pc[0], exp_pc[1]);
        end
        $display("[TB] op=%0d pc=%h addr=%h imm=%h taken=%b reg=%h -> word %h byte %h",
                 o, p, a, im, tk, ra, pc_out_v[0], pc_out_v[1]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (pc_out_v !== '0 || link_out_v !== '0 || link_we_v !== 2'b00 || done_v !== 2'b00 ||
            misalign_v !== 2'b00 || ras_miss_v !== 2'b00 || req_ready_v !== 2'b11) begin
            fails++;
            $display("FAIL reset_state: pc=%h/%h link=%h/%h lwe=%b done=%b mis=%b miss=%b rdy=%b expected zeros, rdy 11",
                     pc_out_v[0], pc_out_v[1], link_out_v[0], link_out_v[1], link_we_v, done_v,
                     misalign_v, ras_miss_v, req_ready_v);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        pulse_reset();
    endtask

    task automatic test_seq();
        do_req(3'd0, 32'h10, 26'h0, 16'h0, 1'b0, 32'h0);
        tests++;
        if (pc_out_v[0] !== 32'h11 || pc_out_v[1] !== 32'h14) begin
            fails++;
            $display("FAIL seq_const: got %h/%h expected 00000011/00000014", pc_out_v[0], pc_out_v[1]);
        end
    endtask

    task automatic test_jump();
        do_req(3'd1, 32'hF000_0040, 26'h0000123, 16'h0, 1'b0, 32'h0);
        tests++;
        if (pc_out_v[0] !== 32'hF000_0123 || pc_out_v[1] !== 32'hF000_048C) begin
            fails++;
            $display("FAIL jump_const: got %h/%h expected f0000123/f000048c", pc_out_v[0], pc_out_v[1]);
        end
    endtask

    task automatic test_branch();
        do_req(3'd4, 32'h20, 26'h0, 16'hFFFD, 1'b1, 32'h0);
        tests++;
        if (pc_out_v[0] !== 32'h1E || pc_out_v[1] !== 32'h18) begin
            fails++;
            $display("FAIL br_taken: got %h/%h expected 0000001e/00000018", pc_out_v[0], pc_out_v[1]);
        end
        do_req(3'd4, 32'h20, 26'h0, 16'hFFFD, 1'b0, 32'h0);
        tests++;
        if (pc_out_v[0] !== 32'h21 || pc_out_v[1] !== 32'h24) begin
            fails++;
            $display("FAIL br_not_taken: got %h/%h expected 00000021/00000024", pc_out_v[0], pc_out_v[1]);
        end
        do_req(3'd4, 32'hFFFF_FFFF, 26'h0, 16'h0, 1'b1, 32'h0);
        tests++;
        if (pc_out_v[0] !== 32'h0 || pc_out_v[1] !== 32'h3) begin
            fails++;
            $display("FAIL br_wrap: got %h/%h expected 00000000/00000003", pc_out_v[0], pc_out_v[1]);
        end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] want;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            do_req(3'd2, 32'h100 + 32'(i), 26'($urandom), 16'h0, 1'b0, 32'h0);
            tests++;
            if (link_out_v[0] !== 32'h101 + 32'(i)) begin
                fails++;
                $display("FAIL jal_link%0d: got %h expected %h", i, link_out_v[0], 32'h101 + 32'(i));
            end
        end
        for (int i = 0; i < 5; i++) begin
            do_req(3'd5, 32'h0, 26'h0, 16'h0, 1'b0, 32'h400);
            want = (i < 4) ? 32'h105 - 32'(i) : 32'h100;
            tests++;
            if (pc_out_v[0] !== want) begin
                fails++;
                $display("FAIL ret%0d: got %h expected %h", i, pc_out_v[0], want);
            end
        end
    endtask

    task automatic test_jr();
        do_req(3'd3, 32'h0, 26'h0, 16'h0, 1'b0, 32'h0000_0042);
        tests++;
        if (pc_out_v[0] !== 32'h10 || pc_out_v[1] !== 32'h42) begin
            fails++;
            $display("FAIL jr_misaligned: got %h/%h expected 00000010/00000042", pc_out_v[0], pc_out_v[1]);
        end
        do_req(3'd3, 32'h0, 26'h0, 16'h0, 1'b0, 32'h40);
    endtask

    task automatic test_reset_abort();
        do_req(3'd2, 32'h300, 26'h55, 16'h0, 1'b0, 32'h0);
        @(negedge clk);
        op = 3'd2; pc = 32'h200; addr = 26'h77; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (done_v !== 2'b00 || pc_out_v !== '0 || link_out_v !== '0 || link_we_v !== 2'b00) begin
            fails++;
            $display("FAIL abort_outputs: done=%b pc=%h/%h link=%h/%h lwe=%b expected all zero",
                     done_v, pc_out_v[0], pc_out_v[1], link_out_v[0], link_out_v[1], link_we_v);
        end
        @(posedge clk); #1;
        tests++;
        if (done_v !== 2'b00) begin
            fails++;
            $display("FAIL abort_no_done: done=%b expected 00", done_v);
        end
        rst = 1'b0;
        model_reset();
        do_req(3'd5, 32'h0, 26'h0, 16'h0, 1'b0, 32'h80);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_req(3'($urandom_range(0, 7)), $urandom, 26'($urandom), 16'($urandom),
                   1'($urandom), $urandom);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) do_req(3'd2, 32'h1000 + 32'(i * 8), 26'($urandom), 16'h0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) do_req(3'd5, 32'h0, 26'h0, 16'h0, 1'b0, $urandom);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; op = '0; pc = '0; addr = '0; imm = '0; taken = 1'b0; reg_addr = '0;
        model_reset();
        test_reset();
        test_seq();
        test_jump();
        test_branch();
        test_ras_overflow();
        test_jr();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
